// File: rtl/urv_dmem_pkg.sv
// urv_dmem_pkg: shared constants, enums and decode helper for the uRV data-memory responder
package urv_dmem_pkg;
    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0010_0000;
    localparam logic [31:0] DONE_ADDR_DEF    = 32'h0010_0004;
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    typedef enum logic [1:0] {REG_RAM, REG_CON, REG_DONE, REG_UNM} region_e;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_STALL} state_e;
    function automatic region_e region_of(input logic [31:0] a, input logic [31:0] con, input logic [31:0] done);
        return a < con ? REG_RAM : a == con ? REG_CON : a == done ? REG_DONE : REG_UNM;
    endfunction
endpackage

// File: rtl/urv_sync_fifo.sv
// urv_sync_fifo: show-ahead synchronous FIFO, push ignored when full, pop ignored when empty
module urv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rp];
    // pointers and occupancy; a flush only needs these cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage, no reset so it can map onto RAM primitives
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end
endmodule

// File: rtl/urv_dmem_responder.sv
// urv_dmem_responder: uRV data-memory slave with byte-lane RAM, console TX FIFO and test-done register
module urv_dmem_responder
    import urv_dmem_pkg::*;
#(
    parameter int          RAM_WORDS    = 16384,
    parameter int          WAIT_STATES  = 0,
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [31:0] DONE_ADDR    = DONE_ADDR_DEF,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_ready_o,
    input  logic        ld_we_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i,
    output logic [7:0]  con_data_o,
    output logic        con_valid_o,
    input  logic        con_ready_i,
    output logic        test_done_o,
    output logic [31:0] test_code_o,
    output logic        err_o
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] CNT_INIT = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
    state_e state;
    region_e cur_reg;
    logic [3:0] cnt;
    logic [31:0] addr_q, data_q, cur_addr, cur_data, rd_val, status;
    logic [3:0] sel_q;
    logic st_q, ld_q, cur_st, cur_ld, accept, fire, push;
    logic con_full, con_empty;
    logic [CW-1:0] con_count;
    logic [31:0] ram [RAM_WORDS];
    logic unused_ld;
    assign unused_ld = ^ld_addr_i[31:AW];
    assign accept = dm_ready_o & (dm_load_i | dm_store_i);
    assign fire = (state == S_IDLE && accept && WAIT_STATES == 0) || (state == S_WAIT && cnt == 4'd0) ||
                  (state == S_STALL && !con_full);
    assign push = fire && cur_st && cur_reg == REG_CON && !con_full;
    assign cur_reg = region_of(cur_addr, CONSOLE_ADDR, DONE_ADDR);
    assign con_valid_o = |con_count;
    // the request being decided: live inputs on the accept cycle, captured copy afterwards
    always_comb begin
        cur_addr = state == S_IDLE ? dm_addr_i : addr_q;
        cur_data = state == S_IDLE ? dm_data_s_i : data_q;
        cur_st   = state == S_IDLE ? dm_store_i : st_q;
        cur_ld   = state == S_IDLE ? dm_load_i & ~dm_store_i : ld_q;
        status = '0;
        status[STAT_FULL]  = con_full;
        status[STAT_EMPTY] = con_empty;
        rd_val = cur_reg == REG_RAM  ? ram[cur_addr[AW+1:2]] :
                 cur_reg == REG_CON  ? status :
                 cur_reg == REG_DONE ? {31'b0, test_done_o} : '0;
    end
    // request FSM: accept, optional wait countdown, console stall, one-cycle response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= S_IDLE;
            cnt             <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            sel_q           <= '0;
            st_q            <= 1'b0;
            ld_q            <= 1'b0;
            dm_ready_o      <= 1'b1;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_data_l_o     <= '0;
            test_done_o     <= 1'b0;
            test_code_o     <= '0;
            err_o           <= 1'b0;
        end else begin
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            if (accept) begin
                addr_q     <= dm_addr_i;
                data_q     <= dm_data_s_i;
                sel_q      <= dm_data_select_i;
                st_q       <= dm_store_i;
                ld_q       <= dm_load_i & ~dm_store_i;
                dm_ready_o <= 1'b0;
                err_o      <= err_o | (dm_load_i & dm_store_i) | (cur_reg == REG_UNM);
                state      <= S_WAIT;
                cnt        <= CNT_INIT;
            end
            if (state == S_WAIT) cnt <= cnt - 4'd1;
            if (fire) begin
                if (cur_st && cur_reg == REG_CON && con_full) begin
                    state <= S_STALL;
                end else begin
                    state           <= S_RESP;
                    dm_load_done_o  <= cur_ld;
                    dm_store_done_o <= cur_st;
                    if (cur_ld) dm_data_l_o <= rd_val;
                    if (cur_st && cur_reg == REG_DONE) begin
                        test_done_o <= 1'b1;
                        test_code_o <= cur_data;
                    end
                end
            end
            if (state == S_RESP) begin
                state      <= S_IDLE;
                dm_ready_o <= 1'b1;
            end
        end
    end
    // RAM: CPU lane writes land in the done cycle; the backdoor write is last so it wins
    always_ff @(posedge clk_i) begin
        if (state == S_RESP && st_q && region_of(addr_q, CONSOLE_ADDR, DONE_ADDR) == REG_RAM)
            for (int i = 0; i < 4; i++)
                if (sel_q[i]) ram[addr_q[AW+1:2]][8*i +: 8] <= data_q[8*i +: 8];
        if (ld_we_i) ram[ld_addr_i[AW-1:0]] <= ld_data_i;
    end
    urv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_con_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .push  (push),
        .wdata (cur_data[7:0]),
        .pop   (con_valid_o & con_ready_i),
        .rdata (con_data_o),
        .full  (con_full),
        .empty (con_empty),
        .count (con_count)
    );
endmodule

// File: tb/tb_urv_dmem_responder.sv
// tb_urv_dmem_responder: directed bench with load/console scoreboards for the data-memory responder
module tb_urv_dmem_responder;
    localparam logic [31:0] CON  = 32'h0010_0000;
    localparam logic [31:0] DONE = 32'h0010_0004;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] addr = '0, data_s = '0, ld_addr = '0, ld_data = '0;
    logic [3:0] sel = '0;
    logic store = 1'b0, load = 1'b0, ld_we = 1'b0, con_ready = 1'b0;
    logic [31:0] data_l, test_code;
    logic ld_done, st_done, ready, con_valid, test_done, err;
    logic [7:0] con_data;
    logic [31:0] w_addr = '0, w_data_s = '0, w_data_l, w_code;
    logic [3:0] w_sel = '0;
    logic w_store = 1'b0, w_load = 1'b0;
    logic w_ld_done, w_st_done, w_ready, w_con_valid, w_test_done, w_err;
    logic [7:0] w_con_data;
    int checks = 0, errors = 0, pops = 0;
    logic [31:0] ld_q [$];
    logic [7:0] con_q [$];

    always #5 clk = ~clk;

    urv_dmem_responder #(.RAM_WORDS(1024), .WAIT_STATES(0), .FIFO_DEPTH(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(addr), .dm_data_s_i(data_s), .dm_data_select_i(sel),
        .dm_store_i(store), .dm_load_i(load), .dm_data_l_o(data_l), .dm_load_done_o(ld_done),
        .dm_store_done_o(st_done), .dm_ready_o(ready), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
        .ld_data_i(ld_data), .con_data_o(con_data), .con_valid_o(con_valid), .con_ready_i(con_ready),
        .test_done_o(test_done), .test_code_o(test_code), .err_o(err));

    urv_dmem_responder #(.RAM_WORDS(256), .WAIT_STATES(3), .FIFO_DEPTH(4)) dut_w (
        .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(w_addr), .dm_data_s_i(w_data_s), .dm_data_select_i(w_sel),
        .dm_store_i(w_store), .dm_load_i(w_load), .dm_data_l_o(w_data_l), .dm_load_done_o(w_ld_done),
        .dm_store_done_o(w_st_done), .dm_ready_o(w_ready), .ld_we_i(1'b0), .ld_addr_i(32'h0),
        .ld_data_i(32'h0), .con_data_o(w_con_data), .con_valid_o(w_con_valid), .con_ready_i(1'b1),
        .test_done_o(w_test_done), .test_code_o(w_code), .err_o(w_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit w, input logic l, input logic s, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] sl);
        int t = 0;
        while (!(w ? w_ready : ready) && t < 100) begin
            step();
            t++;
        end
        if (w) begin
            w_load = l; w_store = s; w_addr = a; w_data_s = d; w_sel = sl;
        end else begin
            load = l; store = s; addr = a; data_s = d; sel = sl;
        end
        step();
        {load, store, w_load, w_store} = '0;
    endtask

    task automatic wait_done(input bit w, output int lat);
        lat = 1;
        while (!(w ? (w_ld_done | w_st_done) : (ld_done | st_done)) && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic access(input bit w, input logic l, input logic s, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] sl, input int exp_lat, input string tag);
        int lat;
        issue(w, l, s, a, d, sl);
        wait_done(w, lat);
        chk(tag, lat, exp_lat);
    endtask

    task automatic load0(input logic [31:0] a, input logic [31:0] exp, input string tag);
        ld_q.push_back(exp);
        access(0, 1, 0, a, 0, 4'h0, 1, tag);
    endtask

    task automatic backdoor(input logic [31:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_we = 1'b0;
    endtask

    // scoreboard: every load completion and every console pop is matched against what was issued
    always @(negedge clk) begin
        if (rst_n) begin
            if (ld_done) begin
                if (ld_q.size() == 0) chk("load_done_unexpected", {31'b0, ld_done}, 32'h0);
                else chk("load_data", data_l, ld_q.pop_front());
            end
            if (con_valid && con_ready) begin
                if (con_q.size() == 0) chk("con_unexpected", {31'b0, con_valid}, 32'h0);
                else chk("con_byte", {24'b0, con_data}, {24'b0, con_q.pop_front()});
                pops++;
            end
        end
    end

    initial begin
        int lat, t;
        logic seen;
        step(3);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_done_pulses", {30'b0, ld_done, st_done}, 32'h0);
        chk("rst_data_l", data_l, 32'h0);
        chk("rst_con_valid", {31'b0, con_valid}, 32'h0);
        chk("rst_test", {31'b0, test_done}, 32'h0);
        chk("rst_code", test_code, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        rst_n = 1'b1;
        step();
        backdoor(32'd4, 32'hDEAD_BEEF);
        backdoor(32'd8, 32'hFFFF_FFFF);
        ld_q.push_back(32'hDEAD_BEEF);
        issue(0, 1, 0, 32'h10, 0, 4'h0);
        chk("ld_done_n1", {31'b0, ld_done}, 32'h1);
        chk("ready_low_n1", {31'b0, ready}, 32'h0);
        step();
        chk("ready_high_n2", {31'b0, ready}, 32'h1);
        chk("ld_done_one_cycle", {31'b0, ld_done}, 32'h0);
        chk("data_l_held", data_l, 32'hDEAD_BEEF);
        access(0, 0, 1, 32'h20, 32'h1122_3344, 4'b0101, 1, "store_lat");
        load0(32'h20, 32'hFF22_FF44, "lane_load_lat");
        access(0, 0, 1, 32'h20, 32'h0, 4'b0000, 1, "sel0_store_lat");
        load0(32'h20, 32'hFF22_FF44, "sel0_load_lat");
        load0(32'h1010, 32'hDEAD_BEEF, "wrap_load_lat");
        load0(CON, 32'h2, "con_status_empty");
        for (int i = 0; i < 8; i++) begin
            con_q.push_back(8'h41 + 8'(i));
            access(0, 0, 1, CON, 32'hFFFF_FF41 + 32'(i), 4'h0, 1, "con_store_lat");
        end
        load0(CON, 32'h1, "con_status_full");
        con_q.push_back(8'h49);
        issue(0, 0, 1, CON, 32'h49, 4'hF);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | st_done | ready;
            step();
        end
        chk("stall_holds", {31'b0, seen}, 32'h0);
        con_ready = 1'b1;
        wait_done(0, lat);
        chk("stall_released", {31'b0, st_done}, 32'h1);
        chk("stall_after_pop", {31'b0, pops >= 1}, 32'h1);
        t = 0;
        while (con_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        step();
        chk("con_pops", pops, 32'd9);
        chk("con_drained", {31'b0, con_valid}, 32'h0);
        access(0, 0, 1, DONE, 32'h1, 4'hF, 1, "done_store_lat");
        chk("test_done", {31'b0, test_done}, 32'h1);
        chk("test_code", test_code, 32'h1);
        chk("err_clean", {31'b0, err}, 32'h0);
        load0(DONE, 32'h1, "done_load");
        load0(32'h0020_0000, 32'h0, "unmapped_load");
        chk("unmapped_err", {31'b0, err}, 32'h1);
        access(1, 0, 1, 32'h8, 32'h55, 4'hF, 4, "ws3_store_lat");
        issue(1, 1, 0, 32'h8, 0, 4'h0);
        chk("ws3_ready_low", {31'b0, w_ready}, 32'h0);
        wait_done(1, lat);
        chk("ws3_load_lat", lat, 32'd4);
        chk("ws3_load_data", w_data_l, 32'h55);
        issue(1, 1, 0, 32'h8, 0, 4'h0);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, w_ready}, 32'h1);
        chk("arst_no_done", {31'b0, w_ld_done}, 32'h0);
        chk("arst_data_l", w_data_l, 32'h0);
        chk("arst_test_done", {31'b0, test_done}, 32'h0);
        chk("arst_err", {31'b0, err}, 32'h0);
        step(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | w_ld_done;
        end
        chk("aborted_no_done", {31'b0, seen}, 32'h0);
        access(1, 1, 0, 32'h8, 0, 4'h0, 4, "ws3_reload_lat");
        chk("ws3_ram_kept", w_data_l, 32'h55);
        load0(32'h10, 32'hDEAD_BEEF, "ram_kept_lat");
        backdoor(32'd0, 32'h0);
        access(0, 1, 1, 32'h0, 32'hA5A5_A5A5, 4'hF, 1, "ldst_lat");
        chk("ldst_store_only", {30'b0, ld_done, st_done}, 32'h1);
        chk("ldst_err", {31'b0, err}, 32'h1);
        load0(32'h0, 32'hA5A5_A5A5, "ldst_load");
        issue(0, 0, 1, 32'h40, 32'h1234_5678, 4'hF);
        chk("bd_store_ack", {31'b0, st_done}, 32'h1);
        backdoor(32'd16, 32'hCAFE_F00D);
        load0(32'h40, 32'hCAFE_F00D, "bd_wins");
        step(2);
        chk("loads_drained", ld_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
